// File: rtl/mult18_arb_pkg.sv
// Shared widths and shadow-pipeline payload for the shared 18x18 multiplier arbiter.
package mult18_arb_pkg;

  localparam int unsigned MUL_W    = 18;
  localparam int unsigned P_W      = 36;
  localparam int unsigned PIPE_LAT = 2;
  // Widest requester ID supported (NREQ up to 8).
  localparam int unsigned ID_MAX_W = 3;

  // One shadow stage: valid, owning requester, operand sign flags.
  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
    logic                sa;
    logic                sb;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first active request at or above the pointer, with wrap.
module rr_arbiter
  import mult18_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [IDW-1:0] cand;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mult18_share_arb.sv
// Time-shares one registered 18x18 multiplier primitive among NREQ requesters.
// A two-stage shadow pipe carries valid/ID beside the primitive's A/B and P registers.
module mult18_share_arb
  import mult18_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clk_node,
  input  logic                  rsta_asyn_n,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*MUL_W-1:0] req_a,
  input  logic [NREQ*MUL_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_sa,
  input  logic [NREQ-1:0]       req_sb,
  output logic [MUL_W-1:0]      mul_a,
  output logic [MUL_W-1:0]      mul_b,
  output logic                  mul_signeda,
  output logic                  mul_signedb,
  output logic                  mul_cea,
  output logic                  mul_ceb,
  output logic                  mul_cepd,
  input  logic [P_W-1:0]        mul_p,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [P_W-1:0]        rsp_p,
  input  logic                  rsp_ready
);

  shadow_t         s1;
  shadow_t         s2;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            stall;
  logic            hs;
  logic            unused_s2;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  // Backpressure freezes the primitive registers and the shadow pipe together.
  assign stall = s2.v & ~rsp_ready;
  assign hs    = gnt_any & ~stall & ~flush;

  // Grant and operand mux; operands are zero when nothing is issued.
  assign req_ready = hs ? gnt : '0;
  assign mul_a     = hs ? req_a[MUL_W*gnt_idx +: MUL_W] : '0;
  assign mul_b     = hs ? req_b[MUL_W*gnt_idx +: MUL_W] : '0;

  // Sign flags follow the operands into the primitive's input register stage.
  assign mul_signeda = s1.sa;
  assign mul_signedb = s1.sb;
  assign mul_cea     = ~stall;
  assign mul_ceb     = ~stall;
  assign mul_cepd    = ~stall;

  assign rsp_valid = s2.v;
  assign rsp_id    = s2.id[IDW-1:0];
  assign rsp_p     = mul_p;

  // Stage 2 only needs valid and ID; its sign bits are never consumed.
  assign unused_s2 = ^{s2.sa, s2.sb, s2.id};

  // Pointer and shadow pipeline; flush clears in-flight work and the pointer.
  always_ff @(posedge clk_node or negedge rsta_asyn_n) begin
    if (!rsta_asyn_n) begin
      ptr <= '0;
      s1  <= '0;
      s2  <= '0;
    end else if (flush) begin
      ptr <= '0;
      s1  <= '0;
      s2  <= '0;
    end else if (!stall) begin
      s1 <= '{v:  hs,
              id: ID_MAX_W'(gnt_idx),
              sa: hs & req_sa[gnt_idx],
              sb: hs & req_sb[gnt_idx]};
      s2 <= '{v: s1.v, id: s1.id, sa: 1'b0, sb: 1'b0};
      if (hs) begin
        ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult18_share_arb.sv
// Self-checking bench for mult18_share_arb with a behavioural multiplier primitive.
module tb_mult18_share_arb;
  import mult18_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rsp_ready = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_sa, req_sb;
  logic [NREQ*18-1:0] req_a, req_b;
  logic [17:0] a_arr [NREQ];
  logic [17:0] b_arr [NREQ];
  bit sa_arr [NREQ];
  bit sb_arr [NREQ];
  logic [17:0] mul_a, mul_b;
  logic mul_signeda, mul_signedb, mul_cea, mul_ceb, mul_cepd;
  logic [35:0] mul_p, rsp_p;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0; req_b = '0; req_sa = '0; req_sb = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*18 +: 18] = a_arr[i];
      req_b[i*18 +: 18] = b_arr[i];
      req_sa[i] = sa_arr[i];
      req_sb[i] = sb_arr[i];
    end
  end

  mult18_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk_node(clk), .rsta_asyn_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sa(req_sa), .req_sb(req_sb),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signeda(mul_signeda), .mul_signedb(mul_signedb),
    .mul_cea(mul_cea), .mul_ceb(mul_ceb), .mul_cepd(mul_cepd), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready)
  );

  // Primitive stand-in: A/B input registers, sign applied after them, P output register.
  logic [17:0] pa = '0, pb = '0;
  logic [35:0] pp = '0;
  logic signed [18:0] xa, xb;
  logic signed [37:0] xprod;
  always_comb begin
    xa = $signed({mul_signeda & pa[17], pa});
    xb = $signed({mul_signedb & pb[17], pb});
    xprod = xa * xb;
  end
  always @(posedge clk) begin
    if (mul_cea) pa <= mul_a;
    if (mul_ceb) pb <= mul_b;
    if (mul_cepd) pp <= xprod[35:0];
  end
  assign mul_p = pp;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] ref_mul(logic [17:0] a, logic [17:0] b, bit sa, bit sb);
    longint x, y;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    return 36'(x * y);
  endfunction

  // Reference model: in-flight results with their pipeline age, plus the RR pointer.
  typedef struct { int id; logic [35:0] p; int age; } inflight_t;
  inflight_t q[$];
  int ptr_m = 0;
  logic [NREQ-1:0] last_hs = '0;

  always @(negedge clk) begin
    bit exp_v, stall_m;
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [17:0] exp_a, exp_b;
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
      last_hs = '0;
    end else begin
      exp_v = (q.size() > 0) && (q[0].age >= int'(PIPE_LAT));
      chk("mon rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v && rsp_valid) begin
        chk("mon rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("mon rsp_p", 64'(rsp_p), 64'(q[0].p));
      end
      stall_m = exp_v && !rsp_ready;
      g = -1;
      if (!stall_m && !flush) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          int c;
          c = (ptr_m + k) % int'(NREQ);
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      exp_rdy = '0; exp_a = '0; exp_b = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_a = a_arr[g];
        exp_b = b_arr[g];
      end
      chk("mon req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("mon mul_a", 64'(mul_a), 64'(exp_a));
      chk("mon mul_b", 64'(mul_b), 64'(exp_b));
      chk("mon ce", 64'({mul_cea, mul_ceb, mul_cepd}), stall_m ? 64'(0) : 64'(7));
      last_hs = req_valid & req_ready;
      if (exp_v && rsp_ready) void'(q.pop_front());
      if (flush) begin
        q.delete();
        ptr_m = 0;
      end else begin
        if (!stall_m) foreach (q[i]) q[i].age++;
        if (g >= 0) begin
          q.push_back('{id: g, p: ref_mul(a_arr[g], b_arr[g], sa_arr[g], sb_arr[g]), age: 1});
          ptr_m = (g + 1) % int'(NREQ);
        end
      end
    end
  end

  // Advance one cycle; requesters drop valid after their handshake.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~last_hs;
  endtask

  typedef struct { int id; logic [17:0] a; logic [17:0] b; bit sa; bit sb; logic [35:0] p; } vec_t;
  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] bp_exp [3];
    int n;
    vecs[0] = '{0, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 36'hFFFF80001};
    vecs[1] = '{1, 18'h3FFFD, 18'd5,     1'b1, 1'b1, 36'hFFFFFFFF1};
    vecs[2] = '{2, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 36'hFFFFC0001};
    vecs[3] = '{3, 18'd100,   18'd200,   1'b0, 1'b0, 36'h000004E20};
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = '0; b_arr[i] = '0; sa_arr[i] = 1'b0; sb_arr[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'(0));
    chk("rst mul_a", 64'(mul_a), 64'(0));
    chk("rst mul_b", 64'(mul_b), 64'(0));
    chk("rst signed", 64'({mul_signeda, mul_signedb}), 64'(0));
    chk("rst ce", 64'({mul_cea, mul_ceb, mul_cepd}), 64'(7));
    chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst rsp_id", 64'(rsp_id), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Table of single operations
    for (int i = 0; i < 4; i++) begin
      a_arr[vecs[i].id] = vecs[i].a; b_arr[vecs[i].id] = vecs[i].b;
      sa_arr[vecs[i].id] = vecs[i].sa; sb_arr[vecs[i].id] = vecs[i].sb;
      req_valid[vecs[i].id] = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(1) << vecs[i].id);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d early valid", i), 64'(rsp_valid), 64'(0));
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), 64'(rsp_valid), 64'(1));
      chk($sformatf("vec%0d id", i), 64'(rsp_id), 64'(vecs[i].id));
      chk($sformatf("vec%0d p", i), 64'(rsp_p), 64'(vecs[i].p));
      tick();
    end

    // Sign flags must lag operands: signed op followed by unsigned op on req1
    a_arr[1] = 18'h3FFFD; b_arr[1] = 18'd5; sa_arr[1] = 1'b1; sb_arr[1] = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("align ready0", 64'(req_ready), 64'(2));
    tick();
    a_arr[1] = 18'd2; b_arr[1] = 18'd3; sa_arr[1] = 1'b0; sb_arr[1] = 1'b0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    chk("align ready1", 64'(req_ready), 64'(2));
    tick();
    @(negedge clk);
    chk("align p0", 64'(rsp_p), 64'(36'hFFFFFFFF1));
    chk("align id0", 64'(rsp_id), 64'(1));
    tick();
    @(negedge clk);
    chk("align p1", 64'(rsp_p), 64'(36'h6));
    chk("align id1", 64'(rsp_id), 64'(1));
    tick();

    // Round-robin order from a flushed pointer
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = 18'(i + 1); b_arr[i] = 18'(10 * i + 7);
    end
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 8) chk($sformatf("rr grant%0d", k), 64'(req_ready), 64'(1) << (k % 4));
      if (k >= 2) begin
        chk($sformatf("rr valid%0d", k), 64'(rsp_valid), 64'(1));
        chk($sformatf("rr id%0d", k), 64'(rsp_id), 64'((k - 2) % 4));
      end
      tick();
    end

    // Backpressure across three back-to-back operations
    a_arr[0] = 18'd1234;    b_arr[0] = 18'd4321;    sa_arr[0] = 1'b0; sb_arr[0] = 1'b0;
    a_arr[1] = 18'h3FFF0;   b_arr[1] = 18'd7;       sa_arr[1] = 1'b1; sb_arr[1] = 1'b0;
    a_arr[2] = 18'h12345;   b_arr[2] = 18'h3FFFF;   sa_arr[2] = 1'b1; sb_arr[2] = 1'b1;
    for (int i = 0; i < 3; i++) bp_exp[i] = ref_mul(a_arr[i], b_arr[i], sa_arr[i], sb_arr[i]);
    req_valid = 4'b0111;
    @(negedge clk);
    chk("bp grant0", 64'(req_ready), 64'(1));
    tick();
    @(negedge clk);
    chk("bp grant1", 64'(req_ready), 64'(2));
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp hold valid", 64'(rsp_valid), 64'(1));
      chk("bp hold id", 64'(rsp_id), 64'(0));
      chk("bp hold p", 64'(rsp_p), 64'(bp_exp[0]));
      chk("bp ce", 64'({mul_cea, mul_ceb, mul_cepd}), 64'(0));
      chk("bp ready", 64'(req_ready), 64'(0));
      tick();
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid && n < 3) begin
        chk($sformatf("bp order id%0d", n), 64'(rsp_id), 64'(n));
        chk($sformatf("bp order p%0d", n), 64'(rsp_p), 64'(bp_exp[n]));
        n++;
      end
      tick();
    end
    chk("bp count", 64'(n), 64'(3));

    // Reset with two operations in flight
    req_valid = 4'b0011;
    @(negedge clk);
    chk("rstm grant0", 64'(req_ready), 64'(1));
    tick();
    @(negedge clk);
    chk("rstm grant1", 64'(req_ready), 64'(2));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstm no rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rstm ptr0 grant", 64'(req_ready), 64'(2));
    tick();
    @(negedge clk);
    chk("rstm next grant", 64'(req_ready), 64'(8));
    tick();
    repeat (3) tick();

    // Flush drops an extreme signed op; reissue completes
    a_arr[0] = 18'h20000; b_arr[0] = 18'h20000; sa_arr[0] = 1'b1; sb_arr[0] = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("fl grant", 64'(req_ready), 64'(1));
    tick();
    flush = 1'b1;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("fl ready forced 0", 64'(req_ready), 64'(0));
    tick();
    flush = 1'b0;
    req_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fl no rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    req_valid = 4'b0001;
    @(negedge clk);
    chk("fl reissue grant", 64'(req_ready), 64'(1));
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("fl valid", 64'(rsp_valid), 64'(1));
    chk("fl id", 64'(rsp_id), 64'(0));
    chk("fl p", 64'(rsp_p), 64'(36'h400000000));
    tick();

    // Randomized traffic, backpressure and occasional flush
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && $urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 99) < 50) begin
          case ($urandom_range(0, 5))
            0: a_arr[i] = 18'h20000;
            1: a_arr[i] = 18'h3FFFF;
            2: a_arr[i] = 18'h1FFFF;
            default: a_arr[i] = 18'($urandom);
          endcase
          b_arr[i] = ($urandom_range(0, 3) == 0) ? 18'h20000 : 18'($urandom);
          sa_arr[i] = 1'($urandom_range(0, 1));
          sb_arr[i] = 1'($urandom_range(0, 1));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
    end

    // Drain
    flush = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (6) tick();
    chk("drain empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
